multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
- Control FSM for the multi-cycle MIPS-subset datapath. It sits directly upstream of the ALU.
- Decodes op/funct from the instruction register and sequences IF/ID/EX/MEM/WB.
- Drives the 6-bit ALU control code and the mux selects for the ALU operands.
- Consumes the ALU's zero and overflow flags to resolve branches and suppress writeback on signed overflow.

Parameters:
- PC_INC, 4, constant selected on ALU B input for PC increment.
- RA_REG, 31, destination register index for jal.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26]; stable from end of IF until next IF.
- funct  in  6  IR[5:0].
- zero  in  1  ALU ZF (combinational, same cycle).
- ovf  in  1  ALU OF (combinational, same cycle).
- pc_wr  out  1  PC write enable.
- ir_wr  out  1  IR write enable.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- reg_wr  out  1  register-file write enable.
- reg_dst  out  2  0=rt, 1=rd, 2=RA_REG.
- wd_sel  out  2  0=ALUOut, 1=MDR, 2=PC.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  0=rt, 1=PC_INC, 2=ext imm, 3=ext imm<<2.
- ext_op  out  1  1=sign-extend, 0=zero-extend.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- alu_ctrl  out  6  ALU operation code.
- state  out  4  current state (debug).

Behaviour:
- ALU codes:
  - ADDU 000000, SUBU 000001, ADD 000100, SUB 000101.
  - AND 001000, OR 001001, NOT 001010, XOR 001011.
  - EQ 001100, SLT 001110, NULL 111111.
- Supported instructions:
  - R-type (op 000000): funct add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, slt 101010.
  - I-type: addi 001000, addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100.
  - Jumps: j 000010, jal 000011.
- States: IF=0, ID=1, EXR=2, EXI=3, MA=4, MR=5, MWB=6, MW=7, WB=8, BR=9, JMP=10.
- Outputs are Moore-decoded from state plus op/funct, except two Mealy terms: BR pc_wr=zero, and the ov_q capture at end of EXR/EXI.
- Default for every output not listed in a state: 0. Default alu_ctrl is NULL.
- IF:
  - mem_rd=1, ir_wr=1, pc_wr=1, pc_src=0.
  - alu_src_a=0, alu_src_b=1, alu_ctrl=ADDU.
  - Next state: ID.
- ID:
  - alu_src_a=0, alu_src_b=3, ext_op=1, alu_ctrl=ADDU (branch target into ALUOut).
  - Next state by instruction class: R-type→EXR; addi/addiu/ori→EXI; lw/sw→MA; beq→BR; j/jal→JMP; any other op or funct→IF (NOP, no write).
- EXR:
  - alu_src_a=1, alu_src_b=0, alu_ctrl from funct.
  - ov_q <= ovf if add/sub, else 0. Next state: WB.
- EXI:
  - alu_src_a=1, alu_src_b=2, ext_op=0 for ori else 1.
  - alu_ctrl: ADD for addi, ADDU for addiu, OR for ori.
  - ov_q <= ovf for addi only, else 0. Next state: WB.
- WB:
  - reg_wr=!ov_q, reg_dst=1 for R-type else 0, wd_sel=0. Next state: IF.
- MA:
  - alu_src_a=1, alu_src_b=2, ext_op=1, alu_ctrl=ADDU.
  - Next state: MR for lw, MW for sw.
- MR: mem_rd=1; next state MWB.
- MWB: reg_wr=1, reg_dst=0, wd_sel=1; next state IF.
- MW: mem_wr=1; next state IF.
- BR:
  - alu_src_a=1, alu_src_b=0, alu_ctrl=SUBU.
  - pc_wr=zero, pc_src=1. Next state: IF.
- JMP:
  - pc_wr=1, pc_src=2.
  - jal additionally: reg_wr=1, reg_dst=2, wd_sel=2. Next state: IF.
- Latency in cycles: R/I ALU 4, lw 5, sw 4, beq 3, j/jal 3.
- Reset:
  - While rst=1: state=IF asynchronously, ov_q=0.
  - pc_wr, ir_wr, mem_rd, mem_wr, reg_wr are forced 0; alu_ctrl=NULL.
  - Reset mid-instruction abandons the instruction with no write.
  - First IF strobes occur in the first cycle after rst deasserts.
- ov_q is cleared on every entry to IF.
- ovf is ignored outside EXR/EXI.
- zero is ignored outside BR.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - ALU code localparams.
  - opcode/funct constants.
  - state encodings.
  - mux-select encodings for reg_dst, wd_sel, alu_src_b, pc_src.
- Sub-module alu_ctrl_dec: combinational (op, funct, state) → alu_ctrl. Reusable by a later pipelined core.

Test Plan:
- Reset asserted during MR of lw → state=0 immediately; mem_rd, reg_wr and every other write strobe stay 0 until deassert; next IF asserts pc_wr, ir_wr, mem_rd.
- add (op 0, funct 100000) with ovf=1 in EXR → state sequence 0,1,2,8,0; alu_ctrl=000100 in EXR; reg_wr=0 in WB. Repeat with ovf=0 → reg_wr=1, reg_dst=1.
- lw → states 0,1,4,5,6,0; MWB has reg_wr=1, wd_sel=1, reg_dst=0. sw → 0,1,4,7,0 with mem_wr=1 exactly one cycle.
- beq with zero=1 → BR pc_wr=1, pc_src=1, alu_ctrl=000001. With zero=0 → pc_wr=0. Both return to IF after 3 cycles.
- jal → JMP has pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, wd_sel=2. j → same but reg_wr=0.
- ori → alu_ctrl=001001, ext_op=0, ovf=1 ignored (reg_wr=1). Undefined op 111111 → ID→IF with no write strobe.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the multi-cycle MIPS-subset control path.
// Holds the ALU operation codes, opcode/funct values, FSM state encodings,
// the mux-select encodings, and a helper that recognises supported R-type functs.
package cpu_ctrl_pkg;
    localparam int PC_INC = 4;
    localparam int RA_REG = 31;

    localparam logic [5:0] ALU_ADDU = 6'b000000;
    localparam logic [5:0] ALU_SUBU = 6'b000001;
    localparam logic [5:0] ALU_ADD  = 6'b000100;
    localparam logic [5:0] ALU_SUB  = 6'b000101;
    localparam logic [5:0] ALU_AND  = 6'b001000;
    localparam logic [5:0] ALU_OR   = 6'b001001;
    localparam logic [5:0] ALU_NOT  = 6'b001010;
    localparam logic [5:0] ALU_XOR  = 6'b001011;
    localparam logic [5:0] ALU_EQ   = 6'b001100;
    localparam logic [5:0] ALU_SLT  = 6'b001110;
    localparam logic [5:0] ALU_NULL = 6'b111111;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EXR = 4'd2,
        S_EXI = 4'd3,
        S_MA  = 4'd4,
        S_MR  = 4'd5,
        S_MWB = 4'd6,
        S_MW  = 4'd7,
        S_WB  = 4'd8,
        S_BR  = 4'd9,
        S_JMP = 4'd10
    } state_t;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] SB_RT   = 2'd0;
    localparam logic [1:0] SB_INC  = 2'd1;
    localparam logic [1:0] SB_IMM  = 2'd2;
    localparam logic [1:0] SB_IMM2 = 2'd3;

    localparam logic [1:0] PS_ALU    = 2'd0;
    localparam logic [1:0] PS_ALUOUT = 2'd1;
    localparam logic [1:0] PS_JT     = 2'd2;

    function automatic logic r_supported(input logic [5:0] f);
        return f inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_SLT};
    endfunction
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU operation decode from state and instruction fields.
// Ports: op/funct = instruction fields, state = controller state,
//        alu_ctrl = 6-bit ALU operation code (NULL when the ALU is unused).
module alu_ctrl_dec
    import cpu_ctrl_pkg::*;
(
    input  logic   [5:0] op,
    input  logic   [5:0] funct,
    input  state_t       state,
    output logic   [5:0] alu_ctrl
);
    always_comb begin
        alu_ctrl = ALU_NULL;
        case (state)
            S_IF, S_ID, S_MA: alu_ctrl = ALU_ADDU;
            S_BR: alu_ctrl = ALU_SUBU;
            S_EXI: alu_ctrl = op == OP_ADDI ? ALU_ADD : op == OP_ADDIU ? ALU_ADDU :
                              op == OP_ORI ? ALU_OR : ALU_NULL;
            S_EXR: begin
                case (funct)
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_ADDU:  alu_ctrl = ALU_ADDU;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_SUBU:  alu_ctrl = ALU_SUBU;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_XOR:   alu_ctrl = ALU_XOR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_NULL;
                endcase
            end
            default: alu_ctrl = ALU_NULL;
        endcase
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM sequencing IF/ID/EX/MEM/WB for the multi-cycle MIPS-subset datapath.
// Ports: clk/rst (async active-high), op/funct from IR, zero/ovf from the ALU;
//        write strobes pc_wr/ir_wr/mem_rd/mem_wr/reg_wr, mux selects reg_dst/wd_sel/
//        alu_src_a/alu_src_b/pc_src, ext_op, alu_ctrl, and the debug state.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ovf,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [1:0] pc_src,
    output logic [5:0] alu_ctrl,
    output logic [3:0] state
);
    state_t     st, nxt;
    logic       ov_q, jal;
    logic [5:0] alu_dec;

    assign jal = op == OP_JAL;

    always_comb begin
        nxt = S_IF;
        case (st)
            S_IF: nxt = S_ID;
            S_ID: nxt = op == OP_R ? (r_supported(funct) ? S_EXR : S_IF) :
                        op inside {OP_ADDI, OP_ADDIU, OP_ORI} ? S_EXI :
                        op inside {OP_LW, OP_SW} ? S_MA :
                        op == OP_BEQ ? S_BR :
                        op inside {OP_J, OP_JAL} ? S_JMP : S_IF;
            S_EXR, S_EXI: nxt = S_WB;
            S_MA: nxt = op == OP_LW ? S_MR : S_MW;
            S_MR: nxt = S_MWB;
            default: nxt = S_IF;
        endcase
    end

    // ov_q remembers a signed overflow from EX so WB can suppress the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= S_IF;
            ov_q <= 1'b0;
        end else begin
            st   <= nxt;
            ov_q <= st == S_EXR ? ovf && (funct == F_ADD || funct == F_SUB) :
                    st == S_EXI ? ovf && op == OP_ADDI :
                    nxt == S_IF ? 1'b0 : ov_q;
        end
    end

    alu_ctrl_dec u_dec (
        .op       (op),
        .funct    (funct),
        .state    (st),
        .alu_ctrl (alu_dec)
    );

    // State already reads IF during reset; the strobes are masked so nothing is written.
    assign alu_ctrl  = rst ? ALU_NULL : alu_dec;
    assign pc_wr     = !rst && (st == S_IF || st == S_JMP || (st == S_BR && zero));
    assign ir_wr     = !rst && st == S_IF;
    assign mem_rd    = !rst && (st == S_IF || st == S_MR);
    assign mem_wr    = !rst && st == S_MW;
    assign reg_wr    = !rst && ((st == S_WB && !ov_q) || st == S_MWB || (st == S_JMP && jal));
    assign reg_dst   = st == S_WB && op == OP_R ? RD_RD : st == S_JMP && jal ? RD_RA : RD_RT;
    assign wd_sel    = st == S_MWB ? WD_MDR : st == S_JMP && jal ? WD_PC : WD_ALU;
    assign alu_src_a = st inside {S_EXR, S_EXI, S_MA, S_BR};
    assign alu_src_b = st == S_IF ? SB_INC : st == S_ID ? SB_IMM2 :
                       st inside {S_EXI, S_MA} ? SB_IMM : SB_RT;
    assign ext_op    = st == S_ID || st == S_MA || (st == S_EXI && op != OP_ORI);
    assign pc_src    = st == S_BR ? PS_ALUOUT : st == S_JMP ? PS_JT : PS_ALU;
    assign state     = st;
endmodule
